demux1_2_stream: RTL and testbench

DEMUX1_2_STREAM -- requirements
Module: demux1_2_stream

---
 rtl/demux1_2_stream_pkg.sv | 16 +
 rtl/demux1_2_stream_if.sv | 54 +++++
 rtl/stream_slot.sv | 61 ++++++
 rtl/demux1_2_stream.sv | 72 +++++++
 tb/tb_demux1_2_stream.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux1_2_stream_pkg.sv
// Shared constants and types for the 1:2 stream demux.
// Default widths, port-select encoding, buffer slot state.
package demux1_2_stream_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux1_2_stream_if.sv
// Handshake bundle for the 1:2 stream demux.
// master = upstream/downstream environment, slave = demux.
interface demux1_2_stream_if #(
  parameter int WIDTH = demux1_2_stream_pkg::WIDTH_DEF,
  parameter int CNT_W = demux1_2_stream_pkg::CNT_W_DEF
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_ready;

  logic             out_valid0;
  logic [WIDTH-1:0] out_data0;
  logic             out_ready0;

  logic             out_valid1;
  logic [WIDTH-1:0] out_data1;
  logic             out_ready1;

  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in_valid,
    output in_data,
    output in_sel,
    input  in_ready,
    input  out_valid0,
    input  out_data0,
    output out_ready0,
    input  out_valid1,
    input  out_data1,
    output out_ready1,
    input  cnt0,
    input  cnt1
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sel,
    output in_ready,
    output out_valid0,
    output out_data0,
    input  out_ready0,
    output out_valid1,
    output out_data1,
    input  out_ready1,
    output cnt0,
    output cnt1
  );

endinterface

// File: rtl/stream_slot.sv
// One-entry valid/ready buffer: data register plus full flag.
// Accepts while empty or while the held word drains this cycle.
module stream_slot
  import demux1_2_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  slot_state_e      state;
  slot_state_e      state_nx;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      data_q <= data_nx;
    end
  end

  always_comb begin
    state_nx = state;
    data_nx  = data_q;
    in_ready = 1'b0;
    unique case (state)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = FULL;
          data_nx  = in_data;
        end
      end
      FULL: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            data_nx = in_data;
          end else begin
            state_nx = EMPTY;
          end
        end
      end
    endcase
  end

  assign out_valid = (state == FULL);
  assign out_data  = data_q;

endmodule

// File: rtl/demux1_2_stream.sv
// 1:2 stream demux: in_sel steers each word into one of two
// independent one-entry slots; per-port transfer counters.
module demux1_2_stream
  import demux1_2_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  demux1_2_stream_if.slave  bus
);

  logic             sel1;
  logic             v0;
  logic             v1;
  logic             r0;
  logic             r1;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  assign sel1 = (bus.in_sel == PORT1);
  assign v0   = bus.in_valid & ~sel1;
  assign v1   = bus.in_valid & sel1;

  // Only the selected slot gates acceptance; the other may stall freely.
  assign bus.in_ready = ~rst & (sel1 ? r1 : r0);

  stream_slot #(
    .WIDTH(WIDTH)
  ) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v0),
    .in_data  (bus.in_data),
    .in_ready (r0),
    .out_valid(bus.out_valid0),
    .out_data (bus.out_data0),
    .out_ready(bus.out_ready0)
  );

  stream_slot #(
    .WIDTH(WIDTH)
  ) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v1),
    .in_data  (bus.in_data),
    .in_ready (r1),
    .out_valid(bus.out_valid1),
    .out_data (bus.out_data1),
    .out_ready(bus.out_ready1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (bus.out_valid0 && bus.out_ready0) begin
        cnt0_q <= cnt0_q + CNT_W'(1);
      end
      if (bus.out_valid1 && bus.out_ready1) begin
        cnt1_q <= cnt1_q + CNT_W'(1);
      end
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;

endmodule

// File: tb/tb_demux1_2_stream.sv
// Self-checking bench for demux1_2_stream: directed scenarios
// plus a randomized run against a per-port queue model.
module tb_demux1_2_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  demux1_2_stream_if #(.WIDTH(32), .CNT_W(8)) bus ();

  demux1_2_stream #(
    .WIDTH(32),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_sel     = 1'b0;
    bus.out_ready0 = 1'b0;
    bus.out_ready1 = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.out_valid0 !== 1'b0 || bus.out_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b%b exp=00",
               bus.out_valid0, bus.out_valid1);
    end
    checks++;
    if (bus.cnt0 !== 8'd0 || bus.cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.cnt0, bus.cnt1);
    end
    checks++;
    if (bus.out_data0 !== 32'd0 || bus.out_data1 !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=0/0",
               bus.out_data0, bus.out_data1);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
    end
    rst = 1'b0;
    bus.in_data = 32'h5;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready got=%b exp=1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid0 !== 1'b1 || bus.out_data0 !== 32'h5) begin
      failures++;
      $display("FAIL first_xfer got=%b/%h exp=1/5",
               bus.out_valid0, bus.out_data0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 32'hDEADBEEF;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid0 !== 1'b1 || bus.out_data0 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL mid_load got=%b/%h exp=1/deadbeef",
               bus.out_valid0, bus.out_data0);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid0 !== 1'b0 || bus.cnt0 !== 8'd0) begin
      failures++;
      $display("FAIL mid_async got=%b/%0d exp=0/0",
               bus.out_valid0, bus.cnt0);
    end
    bus.out_ready0 = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_valid0 !== 1'b0 || bus.cnt0 !== 8'd0) begin
        failures++;
        $display("FAIL mid_discard got=%b/%0d exp=0/0",
                 bus.out_valid0, bus.cnt0);
      end
    end
  endtask

  task automatic test_stream();
    apply_reset();
    bus.out_ready1 = 1'b1;
    bus.in_sel     = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(i);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready got=%b exp=1", bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid1 !== 1'b1 || bus.out_data1 !== 32'(i) ||
          bus.out_valid0 !== 1'b0) begin
        failures++;
        $display("FAIL stream_word got=%b/%h/%b exp=1/%h/0",
                 bus.out_valid1, bus.out_data1, bus.out_valid0, i);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.cnt1 !== 8'd4 || bus.out_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL stream_cnt got=%0d/%b exp=4/0",
               bus.cnt1, bus.out_valid1);
    end
  endtask

  task automatic test_independence();
    apply_reset();
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 32'hA5;
    tick();
    bus.in_sel  = 1'b1;
    bus.in_data = 32'h77;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL indep_ready1 got=%b exp=1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid1 !== 1'b1 || bus.out_data1 !== 32'h77) begin
      failures++;
      $display("FAIL indep_port1 got=%b/%h exp=1/77",
               bus.out_valid1, bus.out_data1);
    end
    bus.in_sel     = 1'b0;
    bus.in_data    = 32'h33;
    bus.out_ready1 = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL indep_ready0 got=%b exp=0", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid0 !== 1'b1 || bus.out_data0 !== 32'hA5 ||
        bus.cnt1 !== 8'd1 || bus.cnt0 !== 8'd0) begin
      failures++;
      $display("FAIL indep_hold got=%b/%h/%0d/%0d exp=1/a5/1/0",
               bus.out_valid0, bus.out_data0, bus.cnt1, bus.cnt0);
    end
  endtask

  task automatic test_drain_fill();
    apply_reset();
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 32'h10;
    tick();
    bus.in_data    = 32'h11;
    bus.out_ready0 = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL df_ready got=%b exp=1", bus.in_ready);
    end
    tick();
    bus.in_valid   = 1'b0;
    bus.out_ready0 = 1'b0;
    checks++;
    if (bus.out_valid0 !== 1'b1 || bus.out_data0 !== 32'h11 ||
        bus.cnt0 !== 8'd1) begin
      failures++;
      $display("FAIL df_word got=%b/%h/%0d exp=1/11/1",
               bus.out_valid0, bus.out_data0, bus.cnt0);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    bus.out_ready1 = 1'b1;
    bus.in_sel     = 1'b1;
    bus.in_valid   = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      bus.in_data = 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.cnt1 !== 8'd255) begin
      failures++;
      $display("FAIL wrap_255 got=%0d exp=255", bus.cnt1);
    end
    tick();
    checks++;
    if (bus.cnt1 !== 8'd0 || bus.out_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL wrap_0 got=%0d/%b exp=0/0", bus.cnt1, bus.out_valid1);
    end
  endtask

  task automatic test_random();
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          sent = 0;
    int          del0 = 0;
    int          del1 = 0;
    int          cyc = 0;
    logic        iv;
    logic        sel;
    logic        rr0;
    logic        rr1;
    logic        exp_rdy;
    logic [31:0] d;
    apply_reset();
    while ((sent < 10000 || q0.size() != 0 || q1.size() != 0) &&
           cyc < 40000) begin
      cyc++;
      sel = 1'($urandom_range(0, 1));
      d   = $urandom;
      if (sent < 10000) begin
        iv  = ($urandom_range(0, 3) != 0);
        rr0 = 1'($urandom_range(0, 1));
        rr1 = 1'($urandom_range(0, 1));
      end else begin
        iv  = 1'b0;
        rr0 = 1'b1;
        rr1 = 1'b1;
      end
      bus.in_valid   = iv;
      bus.in_sel     = sel;
      bus.in_data    = d;
      bus.out_ready0 = rr0;
      bus.out_ready1 = rr1;
      #1;
      exp_rdy = sel ? (q1.size() == 0 || rr1) : (q0.size() == 0 || rr0);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rnd_ready cyc=%0d got=%b exp=%b",
                 cyc, bus.in_ready, exp_rdy);
      end
      checks++;
      if (bus.out_valid0 !== (q0.size() != 0) ||
          (q0.size() != 0 && bus.out_data0 !== q0[0])) begin
        failures++;
        $display("FAIL rnd_port0 cyc=%0d got=%b/%h exp=%b/%h", cyc,
                 bus.out_valid0, bus.out_data0, q0.size() != 0,
                 q0.size() != 0 ? q0[0] : 32'h0);
      end
      checks++;
      if (bus.out_valid1 !== (q1.size() != 0) ||
          (q1.size() != 0 && bus.out_data1 !== q1[0])) begin
        failures++;
        $display("FAIL rnd_port1 cyc=%0d got=%b/%h exp=%b/%h", cyc,
                 bus.out_valid1, bus.out_data1, q1.size() != 0,
                 q1.size() != 0 ? q1[0] : 32'h0);
      end
      if (rr0 && q0.size() != 0) begin
        void'(q0.pop_front());
        del0++;
      end
      if (rr1 && q1.size() != 0) begin
        void'(q1.pop_front());
        del1++;
      end
      if (iv && exp_rdy) begin
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
        sent++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (sent != 10000 || q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL rnd_timeout got=%0d exp=10000", sent);
    end
    checks++;
    if (del0 + del1 != sent) begin
      failures++;
      $display("FAIL rnd_delivered got=%0d exp=%0d", del0 + del1, sent);
    end
    checks++;
    if (bus.cnt0 !== 8'(del0) || bus.cnt1 !== 8'(del1)) begin
      failures++;
      $display("FAIL rnd_cnt got=%0d/%0d exp=%0d/%0d",
               bus.cnt0, bus.cnt1, 8'(del0), 8'(del1));
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_reset_mid();
    test_stream();
    test_independence();
    test_drain_fill();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
